// File: rtl/mover_asteroides_pkg.sv
// rtl/mover_asteroides_pkg.sv - shared entry layout, directions and sweep states for the asteroid mover
package pkg_asteroides;

   localparam int LARGURA      = 10;
   localparam int PROFUNDIDADE = 16;

   localparam int X_MSB   = 9;
   localparam int X_LSB   = 6;
   localparam int Y_MSB   = 5;
   localparam int Y_LSB   = 2;
   localparam int DIR_MSB = 1;
   localparam int DIR_LSB = 0;

   localparam logic [1:0] DIR_DIREITA  = 2'b00;
   localparam logic [1:0] DIR_ESQUERDA = 2'b01;
   localparam logic [1:0] DIR_BAIXO    = 2'b10;
   localparam logic [1:0] DIR_CIMA     = 2'b11;

   typedef enum logic [2:0] {
      OCIOSO   = 3'd0,
      LER      = 3'd1,
      ESPERA   = 3'd2,
      ESCREVER = 3'd3,
      FIM      = 3'd4
   } estado_t;

endpackage

// File: rtl/mover_asteroides_calcula_movimento.sv
// rtl/mover_asteroides_calcula_movimento.sv - moves one entry a single cell, saturating at 0 and limite
module calcula_movimento
   import pkg_asteroides::*;
(
   input  logic [LARGURA-1:0] entrada,
   input  logic [3:0]         limite,
   output logic [LARGURA-1:0] saida
);

   logic [3:0] x, y, nx, ny;
   logic [1:0] dir;

   always_comb begin
      x   = entrada[X_MSB:X_LSB];
      y   = entrada[Y_MSB:Y_LSB];
      dir = entrada[DIR_MSB:DIR_LSB];
      nx  = x;
      ny  = y;
      case (dir)
         DIR_DIREITA:  if (x < limite) nx = x + 4'd1;
         DIR_ESQUERDA: if (x != 4'd0)  nx = x - 4'd1;
         DIR_BAIXO:    if (y < limite) ny = y + 4'd1;
         default:      if (y != 4'd0)  ny = y - 4'd1;
      endcase
      saida = {nx, ny, dir};
   end

endmodule

// File: rtl/mover_asteroides.sv
// rtl/mover_asteroides.sv - read-modify-write sweep of the asteroid memory with ship collision detection
module mover_asteroides
   import pkg_asteroides::*;
#(
   parameter logic [3:0] NAVE_X = 4'd7,
   parameter logic [3:0] NAVE_Y = 4'd7,
   parameter logic [3:0] LIMITE = 4'd14
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iniciar,
   input  logic [4:0]  num_asteroides,
   input  logic [9:0]  q,
   output logic [3:0]  addr,
   output logic        we,
   output logic [9:0]  data,
   output logic        ocupado,
   output logic        pronto,
   output logic        colisao,
   output logic [3:0]  indice_colisao
);

   estado_t    estado;
   logic [3:0] i;
   logic [4:0] n_lat;
   logic [9:0] movido;
   logic       ultimo;
   logic       coincide;

   calcula_movimento u_calcula_movimento (
      .entrada (q),
      .limite  (LIMITE),
      .saida   (movido)
   );

   assign ultimo   = ({1'b0, i} == (n_lat - 5'd1));
   assign coincide = (data[X_MSB:X_LSB] == NAVE_X) && (data[Y_MSB:Y_LSB] == NAVE_Y);

   // Outputs are registered, so we/data are loaded on the edge that enters ESCREVER
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado         <= OCIOSO;
         i              <= 4'd0;
         n_lat          <= 5'd0;
         addr           <= 4'd0;
         we             <= 1'b0;
         data           <= 10'd0;
         ocupado        <= 1'b0;
         pronto         <= 1'b0;
         colisao        <= 1'b0;
         indice_colisao <= 4'd0;
      end else begin
         case (estado)
            OCIOSO: begin
               we <= 1'b0;
               if (iniciar) begin
                  n_lat          <= (num_asteroides > 5'd16) ? 5'd16 : num_asteroides;
                  i              <= 4'd0;
                  addr           <= 4'd0;
                  colisao        <= 1'b0;
                  indice_colisao <= 4'd0;
                  ocupado        <= 1'b1;
                  if (num_asteroides == 5'd0) begin
                     pronto <= 1'b1;
                     estado <= FIM;
                  end else begin
                     estado <= LER;
                  end
               end
            end
            LER: begin
               estado <= ESPERA;
            end
            ESPERA: begin
               data   <= movido;
               we     <= 1'b1;
               estado <= ESCREVER;
            end
            ESCREVER: begin
               we <= 1'b0;
               if (coincide && !colisao) begin
                  colisao        <= 1'b1;
                  indice_colisao <= i;
               end
               if (ultimo) begin
                  pronto <= 1'b1;
                  estado <= FIM;
               end else begin
                  i      <= i + 4'd1;
                  addr   <= i + 4'd1;
                  estado <= LER;
               end
            end
            FIM: begin
               pronto  <= 1'b0;
               ocupado <= 1'b0;
               estado  <= OCIOSO;
            end
            default: begin
               estado <= OCIOSO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mover_asteroides.sv
// tb/tb_mover_asteroides.sv - directed self-checking bench for mover_asteroides with a registered-address memory model
module tb_mover_asteroides;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        iniciar = 1'b0;
   logic [4:0]  num_asteroides = 5'd0;
   logic [9:0]  q;
   logic [3:0]  addr;
   logic        we;
   logic [9:0]  data;
   logic        ocupado;
   logic        pronto;
   logic        colisao;
   logic [3:0]  indice_colisao;

   logic [9:0]  mem [0:15];
   logic [3:0]  addr_r = 4'd0;
   logic        pl_we = 1'b0;
   logic [3:0]  pl_addr = 4'd0;
   logic [9:0]  pl_data = 10'd0;

   int errors = 0;
   int checks = 0;

   int         wr_cnt;
   logic [3:0] wr_addr [0:31];
   logic [9:0] wr_data [0:31];
   int         p_cyc;
   logic       p_ocu;

   always #5 clk = ~clk;

   mover_asteroides #(.NAVE_X(4'd7), .NAVE_Y(4'd7), .LIMITE(4'd14)) dut (
      .clk            (clk),
      .reset          (reset),
      .iniciar        (iniciar),
      .num_asteroides (num_asteroides),
      .q              (q),
      .addr           (addr),
      .we             (we),
      .data           (data),
      .ocupado        (ocupado),
      .pronto         (pronto),
      .colisao        (colisao),
      .indice_colisao (indice_colisao)
   );

   always @(posedge clk) begin
      addr_r <= addr;
      if (pl_we)   mem[pl_addr] <= pl_data;
      else if (we) mem[addr]    <= data;
   end
   assign q = mem[addr_r];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [3:0] a, input logic [9:0] d);
      pl_addr = a;
      pl_data = d;
      pl_we   = 1'b1;
      @(negedge clk);
      pl_we   = 1'b0;
   endtask

   // Starts a sweep from a negedge; cycle c is the c-th negedge after the accepting edge
   task automatic run(input logic [4:0] n, input int reinj, input bit abort_on_we);
      bit aborted;
      aborted = 0;
      wr_cnt = 0;
      p_cyc  = 0;
      p_ocu  = 1'b0;
      num_asteroides = n;
      iniciar = 1'b1;
      @(negedge clk);
      iniciar = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         if (c == reinj) begin
            iniciar = 1'b1;
            num_asteroides = 5'd5;
         end
         if (c == reinj + 1) iniciar = 1'b0;
         if (we) begin
            if (abort_on_we) begin
               reset = 1'b0;
               aborted = 1;
               break;
            end
            if (wr_cnt < 32) begin
               wr_addr[wr_cnt] = addr;
               wr_data[wr_cnt] = data;
            end
            wr_cnt++;
         end
         if (pronto) begin
            p_cyc = c;
            p_ocu = ocupado;
            break;
         end
         @(negedge clk);
      end
      iniciar = 1'b0;
      if (aborted) begin
         chk("abort_reached", 32'(aborted), 32'd1);
      end else begin
         chk("pronto_seen", 32'(p_cyc != 0), 32'd1);
         @(negedge clk);
         chk("pronto_one_cycle", 32'(pronto), 32'd0);
         chk("ocupado_drops", 32'(ocupado), 32'd0);
      end
   endtask

   initial begin
      @(negedge clk);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_ocupado", 32'(ocupado), 32'd0);
      chk("rst_pronto", 32'(pronto), 32'd0);
      chk("rst_colisao", 32'(colisao), 32'd0);
      chk("rst_indice", 32'(indice_colisao), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Basic move: (0,7,+x) and (14,7,-x)
      preload(4'd0, 10'b0000_0111_00);
      preload(4'd1, 10'b1110_0111_01);
      run(5'd2, 0, 0);
      chk("basic_wr_cnt", 32'(wr_cnt), 32'd2);
      chk("basic_addr0", 32'(wr_addr[0]), 32'd0);
      chk("basic_data0", 32'(wr_data[0]), 32'(10'b0001_0111_00));
      chk("basic_addr1", 32'(wr_addr[1]), 32'd1);
      chk("basic_data1", 32'(wr_data[1]), 32'(10'b1101_0111_01));
      chk("basic_pronto_cyc", 32'(p_cyc), 32'd7);
      chk("basic_ocupado_fim", 32'(p_ocu), 32'd1);
      chk("basic_colisao", 32'(colisao), 32'd0);
      chk("basic_mem1", 32'(mem[1]), 32'(10'b1101_0111_01));

      // Saturation at LIMITE on +x and at 0 on -y
      preload(4'd0, 10'b1110_0011_00);
      preload(4'd1, 10'b0101_0000_11);
      run(5'd2, 0, 0);
      chk("sat_wr_cnt", 32'(wr_cnt), 32'd2);
      chk("sat_data0", 32'(wr_data[0]), 32'(10'b1110_0011_00));
      chk("sat_data1", 32'(wr_data[1]), 32'(10'b0101_0000_11));

      // Two collisions in one sweep; only the first index is kept
      preload(4'd0, 10'b0110_0111_00);
      preload(4'd1, 10'b1000_0111_01);
      run(5'd2, 0, 0);
      chk("col_data0", 32'(wr_data[0]), 32'(10'b0111_0111_00));
      chk("col_data1", 32'(wr_data[1]), 32'(10'b0111_0111_01));
      chk("col_flag", 32'(colisao), 32'd1);
      chk("col_indice", 32'(indice_colisao), 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("col_sticky", 32'(colisao), 32'd1);

      // N=0: no writes, pronto in cycle 1, colisao cleared by the new start
      run(5'd0, 0, 0);
      chk("n0_wr_cnt", 32'(wr_cnt), 32'd0);
      chk("n0_pronto_cyc", 32'(p_cyc), 32'd1);
      chk("n0_colisao_clr", 32'(colisao), 32'd0);

      // N=20 clamps to 16
      for (int k = 0; k < 16; k++) preload(4'(k), 10'b0001_0001_00);
      run(5'd20, 0, 0);
      chk("n20_wr_cnt", 32'(wr_cnt), 32'd16);
      chk("n20_pronto_cyc", 32'(p_cyc), 32'd49);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("n20_addr%0d", k), 32'(wr_addr[k]), 32'(k));
         chk($sformatf("n20_data%0d", k), 32'(wr_data[k]), 32'(10'b0010_0001_00));
      end

      // iniciar while busy is ignored
      for (int k = 0; k < 3; k++) preload(4'(k), 10'b0000_0000_10);
      run(5'd3, 4, 0);
      chk("busy_wr_cnt", 32'(wr_cnt), 32'd3);
      chk("busy_pronto_cyc", 32'(p_cyc), 32'd10);
      chk("busy_data2", 32'(wr_data[2]), 32'(10'b0000_0001_10));

      // Reset asserted during ESCREVER
      for (int k = 0; k < 3; k++) preload(4'(k), 10'b0011_0011_00);
      run(5'd3, 0, 1);
      #1;
      chk("abort_we", 32'(we), 32'd0);
      chk("abort_ocupado", 32'(ocupado), 32'd0);
      chk("abort_addr", 32'(addr), 32'd0);
      chk("abort_data", 32'(data), 32'd0);
      chk("abort_pronto", 32'(pronto), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      chk("abort_mem0_kept", 32'(mem[0]), 32'(10'b0011_0011_00));
      @(negedge clk);
      run(5'd1, 0, 0);
      chk("restart_wr_cnt", 32'(wr_cnt), 32'd1);
      chk("restart_addr", 32'(wr_addr[0]), 32'd0);
      chk("restart_data", 32'(wr_data[0]), 32'(10'b0100_0011_00));
      chk("restart_pronto_cyc", 32'(p_cyc), 32'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mover_asteroides.md
Name: mover_asteroides

Overview:
- Read-modify-write client of the 16x10 asteroid memory: the master that drives that memory's addr/we/data and consumes its q.
- On each game tick, sweeps entries 0..N-1. Each entry is read, advanced one cell in its direction, checked against the ship position, and written back.
- Sits between the game-tick FSM and the asteroid memory; reports completion and first collision.

Parameters:
- NAVE_X, 7, ship x coordinate (4 bits).
- NAVE_Y, 7, ship y coordinate (4 bits).
- LIMITE, 14, maximum legal coordinate on either axis; minimum is 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  one-cycle start pulse from the tick FSM.
- num_asteroides  in  5  number of live entries N (0..16); values >16 are treated as 16; sampled on accepted iniciar.
- q  in  10  memory read data; entry format is x[9:6], y[5:2], dir[1:0].
- addr  out  4  memory address.
- we  out  1  memory write enable.
- data  out  10  memory write data.
- ocupado  out  1  high from the accepted iniciar until pronto, inclusive.
- pronto  out  1  one-cycle pulse when the sweep completes.
- colisao  out  1  sticky; set if any moved entry lands on (NAVE_X, NAVE_Y); cleared on accepted iniciar.
- indice_colisao  out  4  index of the first colliding entry in the current sweep.

Behaviour:
- Reset (async, reset=0): state=OCIOSO, addr=0, we=0, data=0, ocupado=0, pronto=0, colisao=0, indice_colisao=0, index i=0. Memory contents are not touched. Reset mid-sweep aborts immediately; we drops without waiting for a clock edge.
- Direction codes: 00 +x, 01 -x, 10 +y, 11 -y. dir is never modified.
- Movement arithmetic: 4-bit, saturating to [0, LIMITE].
  - +x at x=LIMITE stays LIMITE.
  - -x at 0 stays 0.
  - Same rules for y.
  - No wrap-around.
- Memory timing: the address is registered inside the memory. q reflects addr one cycle after addr is driven.
- States:
  - OCIOSO: we=0. On iniciar: latch N'=min(N,16); set i=0; clear colisao and indice_colisao; ocupado=1. Go to LER if N'>0, else go to FIM.
  - LER: addr=i, we=0. Next state ESPERA.
  - ESPERA: addr=i, we=0. q is valid this cycle; register f(q) into data_reg. Next state ESCREVER.
  - ESCREVER: addr=i, we=1, data=data_reg.
    - If the new (x,y) equals (NAVE_X, NAVE_Y) and colisao=0: set colisao=1 and indice_colisao=i.
    - If i==N'-1, go to FIM; else i=i+1 and go to LER.
  - FIM: pronto=1 for exactly one cycle, we=0, ocupado=1. Next state OCIOSO with ocupado=0.
- Latency: iniciar accepted at edge E. The first addr appears in the cycle after E. pronto is high in cycle 3N'+1 after E (cycle 1 for N'=0).
- iniciar while ocupado=1: ignored; no restart, no re-latch.
- Only the first collision index is kept. Later collisions in the same sweep leave indice_colisao unchanged.
- Outside ESCREVER: we=0 always, and data holds its last value.

Decomposition:
- Shared package (pkg_asteroides):
  - Field slices X_MSB/X_LSB=9/6, Y_MSB/Y_LSB=5/2, DIR=1/0.
  - Direction constants DIR_DIREITA=00, DIR_ESQUERDA=01, DIR_BAIXO=10, DIR_CIMA=11.
  - State encoding for OCIOSO/LER/ESPERA/ESCREVER/FIM.
  - Entry width 10 and depth 16.
- One sub-module, calcula_movimento: combinational; takes a 10-bit entry and LIMITE, returns the moved entry with saturation. This keeps the FSM free of arithmetic.

Test Plan:
- Memory model preloaded: entry0=0000_0111_00 (0,7,+x), entry1=1110_0111_01 (14,7,-x); iniciar with N=2 → writes 0001_0111_00 at addr0 and 1101_0111_01 at addr1; pronto in cycle 7 after iniciar; colisao=0.
- Saturation: entry0=(14,3,+x), entry1=(5,0,-y) (dir 11); N=2 → written values (14,3,00) and (5,0,11) unchanged; no wrap to 15 or 0.
- Collision: entry0=(6,7,+x), entry1=(8,7,-x); N=2 → both land on (7,7); colisao=1, indice_colisao=0 (first only); colisao stays set until the next iniciar, then clears.
- Edge counts: N=0 → no we asserted, pronto one cycle after iniciar. N=20 → exactly 16 writes, addr 0..15, pronto at cycle 49.
- Robustness: iniciar pulsed again at cycle 4 of a sweep with N=3 → ignored, 3 writes total. reset=0 asserted during ESCREVER → we falls asynchronously, all outputs return to reset values, and the next iniciar restarts at addr 0.
